// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port identifiers and
// the width of the read-latency counter.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester picker; grant is one-hot, bit 0 = port A.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port not served last wins, unless A has fixed priority
      2'b11:   grant = (fixed_prio || last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (A) and the debug/loader
// port (B): one transaction at a time, registered strobes, fixed read latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic                a_ack,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic                b_ack,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  state_t           state, state_nxt;
  port_t            owner, last_grant;
  logic [CNT_W-1:0] cnt;
  logic             m_en_q;
  logic [1:0]       grant;
  logic             ack, rd_ack;

  rr_arb2 u_arb (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      owner      <= PORT_A;
      last_grant <= PORT_B;
      m_en_q     <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
    end else begin
      m_en_q <= 1'b0;
      if (state == IDLE && grant != 2'b00) begin
        m_en_q     <= 1'b1;
        owner      <= grant[1] ? PORT_B : PORT_A;
        last_grant <= grant[1] ? PORT_B : PORT_A;
        m_we       <= grant[1] ? b_we    : a_we;
        m_addr     <= grant[1] ? b_addr  : a_addr;
        m_wdata    <= grant[1] ? b_wdata : a_wdata;
        m_be       <= grant[1] ? b_be    : a_be;
      end
      if (state == ACCESS)
        cnt <= CNT_W'(RD_LATENCY - 1);
      else if (state == RD_WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant != 2'b00) state_nxt = ACCESS;
      ACCESS:  state_nxt = m_we ? IDLE : RD_WAIT;
      RD_WAIT: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack    = 1'b0;
    rd_ack = 1'b0;
    case (state)
      ACCESS:  ack = m_we;
      RD_WAIT: begin
        ack    = (cnt == '0);
        rd_ack = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign m_en    = m_en_q;
  assign busy    = (state != IDLE);
  assign a_ack   = ack && (owner == PORT_A);
  assign b_ack   = ack && (owner == PORT_B);
  assign a_rdata = (rd_ack && owner == PORT_A) ? m_rdata : '0;
  assign b_rdata = (rd_ack && owner == PORT_B) ? m_rdata : '0;

  // A requester must hold its request for the whole of its own transaction
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (busy && owner == PORT_A) |-> a_req);
  b_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (busy && owner == PORT_B) |-> b_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: three configurations run side by side
// against a transaction-timing reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int NI = 3;

  function automatic int lat(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int fixp(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rq_req   [NI][2];
  logic          rq_we    [NI][2];
  logic [AW-1:0] rq_addr  [NI][2];
  logic [DW-1:0] rq_wdata [NI][2];
  logic [BW-1:0] rq_be    [NI][2];
  logic [DW-1:0] mrd      [NI];

  logic          o_aack [NI];
  logic          o_back [NI];
  logic [DW-1:0] o_ard  [NI];
  logic [DW-1:0] o_brd  [NI];
  logic          o_men  [NI];
  logic          o_mwe  [NI];
  logic [AW-1:0] o_maddr[NI];
  logic [DW-1:0] o_mwd  [NI];
  logic [BW-1:0] o_mbe  [NI];
  logic          o_busy [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LATENCY (lat(g)),
      .FIXED_PRIO (fixp(g))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_req   (rq_req[g][0]),
      .a_we    (rq_we[g][0]),
      .a_addr  (rq_addr[g][0]),
      .a_wdata (rq_wdata[g][0]),
      .a_be    (rq_be[g][0]),
      .a_ack   (o_aack[g]),
      .a_rdata (o_ard[g]),
      .b_req   (rq_req[g][1]),
      .b_we    (rq_we[g][1]),
      .b_addr  (rq_addr[g][1]),
      .b_wdata (rq_wdata[g][1]),
      .b_be    (rq_be[g][1]),
      .b_ack   (o_back[g]),
      .b_rdata (o_brd[g]),
      .m_en    (o_men[g]),
      .m_we    (o_mwe[g]),
      .m_addr  (o_maddr[g]),
      .m_wdata (o_mwd[g]),
      .m_be    (o_mbe[g]),
      .m_rdata (mrd[g]),
      .busy    (o_busy[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pct[2];
  bit rd_only, wr_only, fix_mrd, rec;

  // Reference model: the one transaction in flight, described by its timing
  bit            txn_v  [NI];
  int            t_grant[NI];
  int            t_ack  [NI];
  int            t_own  [NI];
  bit            t_we   [NI];
  int            lastg  [NI];
  logic          e_we   [NI];
  logic [AW-1:0] e_addr [NI];
  logic [DW-1:0] e_wdata[NI];
  logic [BW-1:0] e_be   [NI];
  bit            done   [NI][2];
  int            q_port [NI][$];
  int            q_cyc  [NI][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      txn_v[k] = 0; t_grant[k] = -10; t_ack[k] = -10; t_own[k] = 0; t_we[k] = 0;
      lastg[k] = 1;
      e_we[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0; e_be[k] = '0;
      done[k][0] = 0; done[k][1] = 0;
    end
  endtask

  task automatic new_req(input int k, input int p);
    rq_req[k][p]   = 1'b1;
    rq_we[k][p]    = wr_only ? 1'b1 : (rd_only ? 1'b0 : 1'($urandom_range(1)));
    rq_addr[k][p]  = $urandom();
    rq_wdata[k][p] = $urandom();
    rq_be[k][p]    = BW'($urandom_range(15));
  endtask

  task automatic drive();
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (done[k][p]) begin
          rq_req[k][p] = 1'b0;
          done[k][p] = 0;
        end
        if (!rq_req[k][p] && int'($urandom_range(99)) < pct[p]) new_req(k, p);
      end
      mrd[k] = fix_mrd ? 32'h1234_5678 : $urandom();
    end
  endtask

  task automatic check_cycle(input int k);
    bit in_txn, en, ackc, ea, eb;
    in_txn = txn_v[k] && cyc > t_grant[k] && cyc <= t_ack[k];
    en     = txn_v[k] && cyc == t_grant[k] + 1;
    ackc   = txn_v[k] && cyc == t_ack[k];
    ea     = ackc && t_own[k] == 0;
    eb     = ackc && t_own[k] == 1;
    chk($sformatf("u%0d.busy", k),    o_busy[k],  in_txn);
    chk($sformatf("u%0d.m_en", k),    o_men[k],   en);
    chk($sformatf("u%0d.m_we", k),    o_mwe[k],   e_we[k]);
    chk($sformatf("u%0d.m_addr", k),  o_maddr[k], e_addr[k]);
    chk($sformatf("u%0d.m_wdata", k), o_mwd[k],   e_wdata[k]);
    chk($sformatf("u%0d.m_be", k),    o_mbe[k],   e_be[k]);
    chk($sformatf("u%0d.a_ack", k),   o_aack[k],  ea);
    chk($sformatf("u%0d.b_ack", k),   o_back[k],  eb);
    chk($sformatf("u%0d.a_rdata", k), o_ard[k],   (ea && !t_we[k]) ? mrd[k] : '0);
    chk($sformatf("u%0d.b_rdata", k), o_brd[k],   (eb && !t_we[k]) ? mrd[k] : '0);
    if (ackc) done[k][t_own[k]] = 1;
    if (rec && (o_aack[k] || o_back[k])) begin
      q_port[k].push_back(o_back[k] ? 1 : 0);
      q_cyc[k].push_back(cyc);
    end
  endtask

  task automatic sample(input int k);
    int w;
    bit ra, rb;
    ra = rq_req[k][0];
    rb = rq_req[k][1];
    if ((!txn_v[k] || cyc > t_ack[k]) && (ra || rb)) begin
      if (ra && rb) w = fixp(k) ? 0 : (lastg[k] == 0 ? 1 : 0);
      else          w = ra ? 0 : 1;
      txn_v[k]   = 1;
      t_grant[k] = cyc;
      t_own[k]   = w;
      t_we[k]    = rq_we[k][w];
      t_ack[k]   = cyc + 1 + (t_we[k] ? 0 : lat(k));
      lastg[k]   = w;
      e_we[k]    = rq_we[k][w];
      e_addr[k]  = rq_addr[k][w];
      e_wdata[k] = rq_wdata[k][w];
      e_be[k]    = rq_be[k][w];
    end
  endtask

  task automatic tick();
    drive();
    #1;
    for (int k = 0; k < NI; k++) check_cycle(k);
    for (int k = 0; k < NI; k++) sample(k);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit all_quiet();
    for (int k = 0; k < NI; k++) begin
      if (rq_req[k][0] || rq_req[k][1]) return 0;
      if (txn_v[k] && cyc <= t_ack[k]) return 0;
    end
    return 1;
  endfunction

  task automatic drain();
    bit ok;
    ok = 0;
    pct[0] = 0;
    pct[1] = 0;
    for (int n = 0; n < 200; n++) begin
      if (all_quiet()) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("drain_done", ok, 1'b1);
  endtask

  task automatic eval_contention(input bit wr);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.acks_seen", k), q_port[k].size() >= 4, 1'b1);
      for (int i = 0; i < q_port[k].size(); i++) begin
        if (fixp(k) != 0)
          chk($sformatf("u%0d.fixed_owner", k), q_port[k][i], 0);
        else if (i > 0)
          chk($sformatf("u%0d.rr_alternate", k), q_port[k][i], 1 - q_port[k][i-1]);
        if (i > 0)
          chk($sformatf("u%0d.ack_spacing", k), q_cyc[k][i] - q_cyc[k][i-1],
              wr ? 2 : lat(k) + 2);
      end
      q_port[k].delete();
      q_cyc[k].delete();
    end
  endtask

  task automatic set_all_a(input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    for (int k = 0; k < NI; k++) begin
      rq_req[k][0] = 1'b1; rq_we[k][0] = we; rq_addr[k][0] = addr;
      rq_wdata[k][0] = wdata; rq_be[k][0] = be;
    end
  endtask

  task automatic check_reset_outputs(input string when);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.u%0d.busy", when, k),   o_busy[k],  1'b0);
      chk($sformatf("%s.u%0d.m_en", when, k),   o_men[k],   1'b0);
      chk($sformatf("%s.u%0d.m_we", when, k),   o_mwe[k],   1'b0);
      chk($sformatf("%s.u%0d.a_ack", when, k),  o_aack[k],  1'b0);
      chk($sformatf("%s.u%0d.b_ack", when, k),  o_back[k],  1'b0);
      chk($sformatf("%s.u%0d.m_addr", when, k), o_maddr[k], '0);
      chk($sformatf("%s.u%0d.m_wdata", when, k), o_mwd[k],  '0);
      chk($sformatf("%s.u%0d.m_be", when, k),   o_mbe[k],   '0);
    end
  endtask

  initial begin
    bit hit;
    for (int k = 0; k < NI; k++)
      for (int p = 0; p < 2; p++) begin
        rq_req[k][p] = 1'b0; rq_we[k][p] = 1'b0; rq_addr[k][p] = '0;
        rq_wdata[k][p] = '0; rq_be[k][p] = '0;
      end
    for (int k = 0; k < NI; k++) mrd[k] = '0;
    pct[0] = 0; pct[1] = 0;
    rd_only = 0; wr_only = 0; fix_mrd = 0; rec = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    set_all_a(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    repeat (4) tick();

    fix_mrd = 1;
    set_all_a(1'b0, 32'h40, '0, 4'hF);
    repeat (8) tick();
    fix_mrd = 0;
    drain();

    rd_only = 1; rec = 1;
    pct[0] = 100; pct[1] = 100;
    repeat (40) tick();
    rec = 0;
    eval_contention(1'b0);
    drain();
    rd_only = 0;

    wr_only = 1; rec = 1;
    pct[0] = 100; pct[1] = 100;
    repeat (30) tick();
    rec = 0;
    eval_contention(1'b1);
    pct[0] = 0;
    repeat (10) tick();
    drain();
    wr_only = 0;

    for (int n = 0; n < 2000; n++) begin
      pct[0] = int'($urandom_range(100));
      pct[1] = int'($urandom_range(100));
      tick();
    end
    drain();

    set_all_a(1'b0, 32'h80, '0, 4'hF);
    hit = 0;
    for (int n = 0; n < 12; n++) begin
      if (txn_v[0] && !t_we[0] && cyc >= t_grant[0] + 2 && cyc <= t_ack[0]) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("reach_rd_wait", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midread");
    model_reset();
    for (int k = 0; k < NI; k++)
      for (int p = 0; p < 2; p++) begin
        done[k][p] = 0;
        new_req(k, p);
        rq_we[k][p] = 1'b0;
      end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < NI; k++)
      chk($sformatf("u%0d.first_after_reset", k), o_maddr[k], rq_addr[k][0]);
    repeat (12) tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
